// File: rtl/exception_vector_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : exception_vector_fetch_if
// Brief    : Bus between the exception sequencer and the CPU datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface exception_vector_fetch_if;
  logic        exc_opcode;
  logic        exc_overflow;
  logic        exc_div0;
  logic [31:0] pc_current;
  logic [31:0] mem_data_in;
  logic [2:0]  addr_sel;
  logic        addr_override;
  logic        mem_wr;
  logic [31:0] epc_out;
  logic        epc_write;
  logic [31:0] pc_out;
  logic        pc_write;
  logic        busy;
  logic        done;
  logic [1:0]  cause;

  // master is the sequencer, slave is the datapath/control side
  modport master (
    input  exc_opcode, exc_overflow, exc_div0, pc_current, mem_data_in,
    output addr_sel, addr_override, mem_wr, epc_out, epc_write,
           pc_out, pc_write, busy, done, cause
  );

  modport slave (
    output exc_opcode, exc_overflow, exc_div0, pc_current, mem_data_in,
    input  addr_sel, addr_override, mem_wr, epc_out, epc_write,
           pc_out, pc_write, busy, done, cause
  );
endinterface
`default_nettype wire

// File: rtl/exception_vector_fetch.sv
`default_nettype none
// ============================================================================
// Module   : exception_vector_fetch
// Brief    : Exception sequencer: saves EPC, steers the address mux to vector
//            253/254/255, waits for memory and loads the vector byte into PC.
//            Optional macro EXC_CAUSE_REG_EN exposes the last taken cause.
// Revision : 1.0 - initial release
// ============================================================================
module exception_vector_fetch #(
  parameter int MEM_WAIT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  exception_vector_fetch_if.master exc_bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SAVE_EPC = 3'd1,
    S_ADDR     = 3'd2,
    S_WAIT     = 3'd3,
    S_LOAD     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [3:0]  c_WAIT_LOAD    = 4'(MEM_WAIT - 1);
  localparam logic [1:0]  c_CAUSE_NONE   = 2'b00;
  localparam logic [1:0]  c_CAUSE_OPCODE = 2'b01;
  localparam logic [1:0]  c_CAUSE_OVF    = 2'b10;
  localparam logic [1:0]  c_CAUSE_DIV0   = 2'b11;
  localparam logic [2:0]  c_SEL_NONE     = 3'b000;
  localparam logic [2:0]  c_SEL_253      = 3'b010;
  localparam logic [2:0]  c_SEL_254      = 3'b011;
  localparam logic [2:0]  c_SEL_255      = 3'b100;
  localparam logic [31:0] c_PC_STEP      = 32'd4;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [2:0]  w_vec_sel;
  logic        w_exc_any;
  logic        w_unused_mem_hi;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      cause_q <= c_CAUSE_NONE;
      epc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    case (cause_q)
      c_CAUSE_OPCODE: w_vec_sel = c_SEL_253;
      c_CAUSE_OVF:    w_vec_sel = c_SEL_254;
      c_CAUSE_DIV0:   w_vec_sel = c_SEL_255;
      default:        w_vec_sel = c_SEL_NONE;
    endcase
  end

  assign w_exc_any = exc_bus.exc_opcode | exc_bus.exc_overflow | exc_bus.exc_div0;

  always_comb begin
    state_d               = state_q;
    cnt_d                 = cnt_q;
    cause_d               = cause_q;
    epc_d                 = epc_q;
    exc_bus.addr_sel      = c_SEL_NONE;
    exc_bus.addr_override = 1'b0;
    exc_bus.epc_write     = 1'b0;
    exc_bus.pc_out        = 32'd0;
    exc_bus.pc_write      = 1'b0;
    exc_bus.done          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_exc_any) begin
          state_d = S_SAVE_EPC;
          epc_d   = exc_bus.pc_current - c_PC_STEP;
          if (exc_bus.exc_opcode)        cause_d = c_CAUSE_OPCODE;
          else if (exc_bus.exc_overflow) cause_d = c_CAUSE_OVF;
          else                           cause_d = c_CAUSE_DIV0;
        end
      end
      S_SAVE_EPC: begin
        // strobes are masked by reset so an aborted sequence never commits
        exc_bus.epc_write = ~reset;
        state_d           = S_ADDR;
      end
      S_ADDR: begin
        exc_bus.addr_override = 1'b1;
        exc_bus.addr_sel      = w_vec_sel;
        cnt_d                 = c_WAIT_LOAD;
        state_d               = S_WAIT;
      end
      S_WAIT: begin
        exc_bus.addr_override = 1'b1;
        exc_bus.addr_sel      = w_vec_sel;
        if (cnt_q == 4'd0) state_d = S_LOAD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_LOAD: begin
        exc_bus.addr_override = 1'b1;
        exc_bus.addr_sel      = w_vec_sel;
        exc_bus.pc_out        = {24'd0, exc_bus.mem_data_in[7:0]};
        exc_bus.pc_write      = ~reset;
        state_d               = S_DONE;
      end
      S_DONE: begin
        exc_bus.done = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign exc_bus.epc_out = epc_q;
  assign exc_bus.busy    = (state_q != S_IDLE);
  assign exc_bus.mem_wr  = 1'b0;

`ifdef EXC_CAUSE_REG_EN
  assign exc_bus.cause = cause_q;
`else
  assign exc_bus.cause = c_CAUSE_NONE;
`endif

  assign w_unused_mem_hi = ^exc_bus.mem_data_in[31:8];

endmodule
`default_nettype wire
